calc_ctrl: RTL and testbench

CALC_CTRL -- requirements
Module: calc_ctrl

---
 rtl/calc_ctrl_if.sv | 45 ++++
 rtl/calc_ctrl.sv | 130 +++++++++++++
 tb/tb_calc_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : calc_ctrl_if
// Description : Bundle of the calc_ctrl signal groups. It carries the token
//               input stream, the bus to the external ALU and the result
//               output stream.
//               slave  : view seen by calc_ctrl
//               master : view seen by the environment (token source, ALU,
//                        result consumer)
// Ports       : in_data/in_valid/in_ready       token stream (ready/valid)
//               chain_en, clear                 control inputs
//               alu_a/alu_b/alu_sel             operands and opcode to the ALU
//               alu_out/alu_flag                combinational ALU response
//               res_data/res_flag/res_err       registered result
//               res_valid/res_ready             result handshake
// Revision    : 1.0 - initial release
// ============================================================================
interface calc_ctrl_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       chain_en;
  logic       clear;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out;
  logic [3:0] alu_flag;
  logic [7:0] res_data;
  logic [3:0] res_flag;
  logic       res_err;
  logic       res_valid;
  logic       res_ready;

  modport slave (
    input  in_data, in_valid, chain_en, clear, alu_out, alu_flag, res_ready,
    output in_ready, alu_a, alu_b, alu_sel, res_data, res_flag, res_err, res_valid
  );

  modport master (
    output in_data, in_valid, chain_en, clear, alu_out, alu_flag, res_ready,
    input  in_ready, alu_a, alu_b, alu_sel, res_data, res_flag, res_err, res_valid
  );
endinterface
`default_nettype wire

// File: rtl/calc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : calc_ctrl
// Description : Sequencer for an external combinational ALU. It collects
//               operand A, operand B and an opcode from a ready/valid token
//               stream, runs a single EXEC cycle and captures the ALU result
//               and flags. The result is held until the consumer accepts it.
//               On handoff the result can optionally be chained back in as
//               the next operand A.
// Ports       : clk    - single clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - calc_ctrl_if.slave (token, ALU and result groups)
// Parameters  : OP_MAX - highest legal opcode; larger opcodes return an error
// Revision    : 1.0 - initial release
// ============================================================================
module calc_ctrl #(
  parameter logic [3:0] OP_MAX = 4'hB
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  calc_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t     state_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [3:0] op_q;
  logic [7:0] res_data_q;
  logic [3:0] res_flag_q;
  logic       res_err_q;
  logic       res_valid_q;

  logic       w_illegal;
  logic       w_in_ready;

  assign w_illegal  = (op_q > OP_MAX);
  // Ready depends only on state, so it is also valid while reset is held.
  assign w_in_ready = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == LOAD_OP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD_A;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      op_q        <= 4'h0;
      res_data_q  <= 8'h00;
      res_flag_q  <= 4'h0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else if (bus.clear) begin
      // Abort takes priority over any token transfer or result handoff.
      // The result data and flags keep their values.
      state_q     <= LOAD_A;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      op_q        <= 4'h0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (bus.in_valid) begin
            a_q     <= bus.in_data;
            state_q <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (bus.in_valid) begin
            b_q     <= bus.in_data;
            state_q <= LOAD_OP;
          end
        end
        LOAD_OP: begin
          if (bus.in_valid) begin
            op_q    <= bus.in_data[3:0];
            state_q <= EXEC;
          end
        end
        EXEC: begin
          // An illegal opcode produces a zeroed result and ignores the ALU output.
          if (w_illegal) begin
            res_data_q <= 8'h00;
            res_flag_q <= 4'h0;
            res_err_q  <= 1'b1;
          end else begin
            res_data_q <= bus.alu_out;
            res_flag_q <= bus.alu_flag;
            res_err_q  <= 1'b0;
          end
          res_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            // An error result is never chained into the next operation.
            if (bus.chain_en && !res_err_q) begin
              a_q     <= res_data_q;
              state_q <= LOAD_B;
            end else begin
              state_q <= LOAD_A;
            end
          end
        end
        default: begin
          state_q <= LOAD_A;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_sel   = op_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_flag  = res_flag_q;
  assign bus.res_err   = res_err_q;
  assign bus.res_valid = res_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_ctrl
// Description : Self-checking bench for calc_ctrl. It provides a behavioural
//               ALU and a transaction-level reference model. Directed
//               scenarios are followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_ctrl;

  localparam logic [3:0] C_OP_MAX = 4'hB;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  calc_ctrl_if bus ();

  calc_ctrl #(.OP_MAX(C_OP_MAX)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU. The result is {flags[3:0], data[7:0]}, with the flags
  // ordered {underflow, overflow, carry, zero}.
  function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    logic [8:0] s;
    logic [7:0] r;
    logic       uf;
    logic       ov;
    logic       cy;
    s  = 9'd0;
    uf = 1'b0;
    ov = 1'b0;
    cy = 1'b0;
    case (op)
      4'h0: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[7:0];
        cy = s[8];
        ov = (a[7] == b[7]) && (r[7] != a[7]);
      end
      4'h1, 4'h2: begin
        r  = a - b;
        uf = (a < b);
        ov = (a[7] != b[7]) && (r[7] != a[7]);
      end
      4'h3:    r = a & b;
      4'h4:    r = a | b;
      4'h5:    r = a ^ b;
      4'h6:    r = ~a;
      4'h7:    r = a << 1;
      4'h8:    r = a >> 1;
      4'h9:    r = a + 8'd1;
      4'hA:    r = a - 8'd1;
      default: r = b;
    endcase
    return {uf, ov, cy, (r == 8'h00), r};
  endfunction

  always_comb {bus.alu_flag, bus.alu_out} = alu_f(bus.alu_a, bus.alu_b, bus.alu_sel);

  // Reference model: the operand registers, the number of tokens gathered
  // toward the current operation, and the status of the result.
  logic [7:0] m_a, m_b, m_rd;
  logic [3:0] m_op, m_rf;
  logic       m_re, m_rv;
  int         m_tokens;   // 0..2 tokens gathered toward the current operation
  bit         m_exec;     // opcode accepted, result due on the next edge
  bit         m_hold;     // result waiting for the consumer

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_a = 8'h00; m_b = 8'h00; m_op = 4'h0;
    m_rd = 8'h00; m_rf = 4'h0; m_re = 1'b0; m_rv = 1'b0;
    m_tokens = 0; m_exec = 0; m_hold = 0;
  endtask

  task automatic model_step();
    logic [11:0] r;
    if (bus.clear) begin
      m_a = 8'h00; m_b = 8'h00; m_op = 4'h0;
      m_re = 1'b0; m_rv = 1'b0;
      m_tokens = 0; m_exec = 0; m_hold = 0;
    end else if (m_exec) begin
      r = alu_f(m_a, m_b, m_op);
      if (m_op > C_OP_MAX) begin
        m_rd = 8'h00; m_rf = 4'h0; m_re = 1'b1;
      end else begin
        m_rd = r[7:0]; m_rf = r[11:8]; m_re = 1'b0;
      end
      m_rv = 1'b1; m_exec = 0; m_hold = 1;
    end else if (m_hold) begin
      if (bus.res_ready) begin
        m_rv = 1'b0; m_hold = 0;
        if (bus.chain_en && !m_re) begin
          m_a = m_rd; m_tokens = 1;
        end else begin
          m_tokens = 0;
        end
      end
    end else if (bus.in_valid) begin
      if (m_tokens == 0) begin
        m_a = bus.in_data; m_tokens = 1;
      end else if (m_tokens == 1) begin
        m_b = bus.in_data; m_tokens = 2;
      end else begin
        m_op = bus.in_data[3:0]; m_tokens = 0; m_exec = 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("in_ready",  {31'd0, bus.in_ready},  {31'd0, !(m_exec || m_hold)});
    chk("alu_a",     {24'd0, bus.alu_a},     {24'd0, m_a});
    chk("alu_b",     {24'd0, bus.alu_b},     {24'd0, m_b});
    chk("alu_sel",   {28'd0, bus.alu_sel},   {28'd0, m_op});
    chk("res_data",  {24'd0, bus.res_data},  {24'd0, m_rd});
    chk("res_flag",  {28'd0, bus.res_flag},  {28'd0, m_rf});
    chk("res_err",   {31'd0, bus.res_err},   {31'd0, m_re});
    chk("res_valid", {31'd0, bus.res_valid}, {31'd0, m_rv});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic tok(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    cycle();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.chain_en  = 1'b0;
    bus.clear     = 1'b0;
    bus.res_ready = 1'b0;
    model_reset();

    // Output values while reset is held
    #3;
    compare_all();
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    #19 rst_n = 1'b1;

    // 200 + 100 wraps to 44 with carry
    bus.res_ready = 1'b1;
    tok(8'd200); tok(8'd100); tok(8'd0);
    chk("d38_valid_early", {31'd0, bus.res_valid}, 32'd0);
    cycle();
    chk("d38_valid", {31'd0, bus.res_valid}, 32'd1);
    chk("d38_data", {24'd0, bus.res_data}, 32'd44);
    chk("d38_carry", {31'd0, bus.res_flag[1]}, 32'd1);
    chk("d38_err", {31'd0, bus.res_err}, 32'd0);
    cycle();                                   // handoff, chain_en=0

    // 9 - 3 = 6, chained: 6 - 2 = 4
    bus.res_ready = 1'b0;
    tok(8'd9); tok(8'd3); tok(8'd1);
    chk("d39_ready_exec", {31'd0, bus.in_ready}, 32'd0);
    cycle();
    chk("d39_ready_done", {31'd0, bus.in_ready}, 32'd0);
    chk("d39_first", {24'd0, bus.res_data}, 32'd6);
    bus.res_ready = 1'b1; bus.chain_en = 1'b1;
    cycle();
    bus.res_ready = 1'b0; bus.chain_en = 1'b0;
    chk("d39_chain_a", {24'd0, bus.alu_a}, 32'd6);
    tok(8'd2); tok(8'd2);
    cycle();
    chk("d39_second", {24'd0, bus.res_data}, 32'd4);
    bus.res_ready = 1'b1;
    cycle();

    // Illegal opcode returns an error and is never chained
    bus.res_ready = 1'b0;
    tok(8'd5); tok(8'd5); tok(8'h0D);
    cycle();
    chk("d40_err", {31'd0, bus.res_err}, 32'd1);
    chk("d40_data", {24'd0, bus.res_data}, 32'd0);
    chk("d40_flag", {28'd0, bus.res_flag}, 32'd0);
    bus.res_ready = 1'b1; bus.chain_en = 1'b1;
    cycle();
    bus.res_ready = 1'b0; bus.chain_en = 1'b0;
    tok(8'd7);                                 // lands in A, so the state was LOAD_A
    chk("d40_loada", {24'd0, bus.alu_a}, 32'd7);

    // Result held under backpressure while tokens are offered
    tok(8'd1); tok(8'd0);
    cycle();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_data = 8'($urandom);
      cycle();
      chk("d41_hold", {23'd0, bus.res_valid, bus.res_data}, {23'd0, 1'b1, 8'd8});
    end
    bus.in_valid = 1'b0; bus.res_ready = 1'b1;
    cycle();
    chk("d41_release", {31'd0, bus.res_valid}, 32'd0);
    bus.res_ready = 1'b0;

    // clear beats a simultaneous opcode token
    tok(8'd10); tok(8'd20);
    bus.clear = 1'b1;
    tok(8'd0);
    bus.clear = 1'b0;
    chk("d42_alu_ab", {16'd0, bus.alu_a, bus.alu_b}, 32'd0);
    tok(8'd3);
    chk("d42_loada", {24'd0, bus.alu_a}, 32'd3);

    // Asynchronous reset during EXEC
    tok(8'd4); tok(8'd0);                      // now in EXEC
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_all();
    #2 rst_n = 1'b1;
    cycle();
    chk("d43_no_valid", {31'd0, bus.res_valid}, 32'd0);
    cycle();
    chk("d43_no_valid2", {31'd0, bus.res_valid}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.in_data   = ($urandom_range(1) != 0) ? 8'($urandom_range(15)) : 8'($urandom);
      bus.res_ready = $urandom_range(1) != 0;
      bus.chain_en  = $urandom_range(1) != 0;
      bus.clear     = ($urandom_range(31) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
